pwm_decoder: RTL and testbench

Receive-side counterpart of the PWM generator. It samples a PWM line in the Clock domain and recovers the Size-bit duty code that produced it. It checks the period of every PWM window, reports lock, and flags malformed periods. It sits at a board input, or on the far end of a cable from a generator, and the generator's Synch signal is not available to it.

---
 rtl/pwm_decoder.sv | 169 ++++++++++++++++
 tb/tb_pwm_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// Recovers the duty code of an incoming PWM line, tracks period lock and flags
// windows whose length falls outside the accepted tolerance band.
module pwm_decoder #(
  parameter int    ClockPeriod_ns = 20,
  parameter int    PWMPeriod_ns   = 20_000,
  parameter string PWMType        = "Front",
  parameter int    Size           = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            PWM,
  output logic [Size-1:0] Data,
  output logic            Valid,
  output logic            Locked,
  output logic            PeriodErr
);

  localparam int TicksPerPeriod = PWMPeriod_ns / ClockPeriod_ns;
  localparam int TicksPerStep   = TicksPerPeriod / (2 ** Size);
  localparam int Tol            = TicksPerStep / 2;
  localparam int CW             = $clog2(TicksPerPeriod + Tol + 1);
  localparam bit IsFront        = (PWMType == "Front");
  localparam bit IsBack         = (PWMType == "Back");

  localparam logic [CW-1:0]   CntOne     = CW'(1);
  localparam logic [CW-1:0]   LenMin     = CW'(TicksPerPeriod - Tol);
  localparam logic [CW-1:0]   LenMax     = CW'(TicksPerPeriod + Tol);
  localparam logic [CW-1:0]   SteadyLast = CW'(TicksPerPeriod - 1);
  localparam logic [CW-1:0]   StepLast   = CW'(TicksPerStep - 1);
  localparam logic [CW-1:0]   StepInit   = CW'(Tol);
  localparam logic [Size:0]   CodeOne    = (Size + 1)'(1);
  localparam logic [Size:0]   CodeTop    = '1;
  localparam logic [Size:0]   CodeMax    = (Size + 1)'(2 ** Size - 1);
  localparam logic [Size-1:0] DataMax    = '1;

  generate
    if (TicksPerStep < 2) begin : g_bad_step
      $error("pwm_decoder: TicksPerStep must be at least 2");
    end
    if (!IsFront && !IsBack) begin : g_bad_type
      $error("pwm_decoder: PWMType must be Front or Back");
    end
  endgenerate

  typedef enum logic [1:0] {UNLOCKED, MEASURE, STEADY} state_t;

  function automatic logic [Size-1:0] sat_code(input logic [Size:0] c);
    return (c > CodeMax) ? DataMax : c[Size-1:0];
  endfunction

  function automatic logic [Size:0] code_inc(input logic [Size:0] c);
    return (c == CodeTop) ? c : c + CodeOne;
  endfunction

  function automatic logic [Size-1:0] level_code(input logic s);
    return s ? DataMax : '0;
  endfunction

  state_t          state, state_nxt;
  logic            sync_p0, sync_p1, prev_p2;
  logic            bnd_p2;
  logic [CW-1:0]   period_cnt, period_nxt, win_len;
  logic [CW-1:0]   step_cnt, step_nxt, step_base;
  logic [Size:0]   code, code_nxt, code_base;
  logic [Size-1:0] data_nxt;
  logic            valid_nxt, locked_nxt, perr_nxt, restart;

  // Stage p2: boundary edge from the synchronised line and its delayed copy
  assign bnd_p2  = IsFront ? (sync_p1 & ~prev_p2) : (~sync_p1 & prev_p2);
  assign win_len = period_cnt + CntOne;

  always_comb begin
    state_nxt  = state;
    period_nxt = period_cnt + CntOne;
    step_base  = step_cnt;
    code_base  = code;
    step_nxt   = step_cnt;
    code_nxt   = code;
    data_nxt   = Data;
    valid_nxt  = 1'b0;
    locked_nxt = Locked;
    perr_nxt   = 1'b0;
    restart    = 1'b0;
    case (state)
      UNLOCKED: begin
        period_nxt = '0;
        if (bnd_p2) begin
          restart   = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (bnd_p2) begin
          restart = 1'b1;
          if ((win_len >= LenMin) && (win_len <= LenMax)) begin
            data_nxt   = sat_code(code);
            valid_nxt  = 1'b1;
            locked_nxt = 1'b1;
          end else begin
            perr_nxt   = 1'b1;
            locked_nxt = 1'b0;
          end
        end else if (win_len == LenMax) begin
          data_nxt   = level_code(sync_p1);
          valid_nxt  = 1'b1;
          locked_nxt = 1'b0;
          period_nxt = '0;
          state_nxt  = STEADY;
        end
      end
      STEADY: begin
        if (bnd_p2) begin
          restart   = 1'b1;
          state_nxt = MEASURE;
        end else if (period_cnt == SteadyLast) begin
          data_nxt   = level_code(sync_p1);
          valid_nxt  = 1'b1;
          period_nxt = '0;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
    if (restart) begin
      period_nxt = '0;
      step_base  = StepInit;
      code_base  = '0;
    end
    // The boundary cycle itself already belongs to the new window
    step_nxt = step_base;
    code_nxt = code_base;
    if (sync_p1 && (state_nxt == MEASURE)) begin
      if (step_base == StepLast) begin
        step_nxt = '0;
        code_nxt = code_inc(code_base);
      end else begin
        step_nxt = step_base + CntOne;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      prev_p2    <= 1'b0;
      state      <= UNLOCKED;
      period_cnt <= '0;
      step_cnt   <= '0;
      code       <= '0;
      Data       <= '0;
      Valid      <= 1'b0;
      Locked     <= 1'b0;
      PeriodErr  <= 1'b0;
    end else begin
      sync_p0    <= PWM;
      sync_p1    <= sync_p0;
      prev_p2    <= sync_p1;
      state      <= state_nxt;
      period_cnt <= period_nxt;
      step_cnt   <= step_nxt;
      code       <= code_nxt;
      Data       <= data_nxt;
      Valid      <= valid_nxt;
      Locked     <= locked_nxt;
      PeriodErr  <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: one Front and one Back instance, every Valid or
// PeriodErr strobe is logged with its cycle and matched against hand-derived events.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_f, pwm_b;
  logic [2:0] f_data, b_data;
  logic       f_valid, f_locked, f_perr;
  logic       b_valid, b_locked, b_perr;

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;
  int rt[0:63];
  int nr    = 0;

  typedef struct {
    int cyc;
    int data;
    int locked;
    int perr;
  } ev_t;

  ev_t fq[$];
  ev_t bq[$];

  pwm_decoder #(.PWMType("Front")) dut_f (
    .Clock(clk), .Reset(rst), .PWM(pwm_f),
    .Data(f_data), .Valid(f_valid), .Locked(f_locked), .PeriodErr(f_perr)
  );

  pwm_decoder #(.PWMType("Back")) dut_b (
    .Clock(clk), .Reset(rst), .PWM(pwm_b),
    .Data(b_data), .Valid(b_valid), .Locked(b_locked), .PeriodErr(b_perr)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe logger, sampled on the falling edge
  always @(negedge clk) begin
    if (f_valid || f_perr) begin
      chk("f_excl", {31'd0, f_valid & f_perr}, 0);
      fq.push_back('{cyc, int'(f_data), int'(f_locked), int'(f_perr)});
    end
    if (b_valid || b_perr) begin
      chk("b_excl", {31'd0, b_valid & b_perr}, 0);
      bq.push_back('{cyc, int'(b_data), int'(b_locked), int'(b_perr)});
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_fdata"}, f_data, 0);
    chk({tag, "_fvalid"}, f_valid, 0);
    chk({tag, "_flocked"}, f_locked, 0);
    chk({tag, "_fperr"}, f_perr, 0);
    chk({tag, "_bdata"}, b_data, 0);
    chk({tag, "_bvalid"}, b_valid, 0);
    chk({tag, "_blocked"}, b_locked, 0);
    chk({tag, "_bperr"}, b_perr, 0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pwm_f = 1'b0;
    pwm_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fq.delete();
    bq.delete();
    nr = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic per_f(input int hi, input int lo);
    rt[nr] = cyc;
    nr++;
    pwm_f = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_f = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic close_f();
    rt[nr] = cyc;
    nr++;
    pwm_f = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic per_b(input int hi, input int lo);
    pwm_b = 1'b1;
    repeat (hi) @(negedge clk);
    rt[nr] = cyc;
    nr++;
    pwm_b = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic exp_ev(input bit bk, input string tag, input int ecyc,
                        input int ed, input int el, input int ee);
    ev_t ev;
    int  n;
    n = bk ? bq.size() : fq.size();
    chk({tag, "_seen"}, (n > 0) ? 1 : 0, 1);
    if (n == 0) return;
    if (bk) ev = bq.pop_front();
    else    ev = fq.pop_front();
    chk({tag, "_cyc"}, ev.cyc, ecyc);
    chk({tag, "_data"}, ev.data, ed);
    chk({tag, "_locked"}, ev.locked, el);
    chk({tag, "_perr"}, ev.perr, ee);
  endtask

  task automatic exp_none(input string tag);
    chk({tag, "_f_extra"}, fq.size(), 0);
    chk({tag, "_b_extra"}, bq.size(), 0);
  endtask

  initial begin
    rst   = 1'b1;
    pwm_f = 1'b0;
    pwm_b = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst0");
    do_reset();

    // 750/250 stream: first edge silent, every later edge reports 6
    repeat (4) per_f(750, 250);
    close_f();
    for (int k = 1; k <= 4; k++) exp_ev(0, $sformatf("t1_%0d", k), rt[k] + 3, 6, 1, 0);
    exp_none("t1");

    // Code sweep 1..7, four periods each
    do_reset();
    for (int c = 1; c <= 7; c++) repeat (4) per_f(c * 125, 1000 - c * 125);
    close_f();
    for (int k = 1; k <= 28; k++)
      exp_ev(0, $sformatf("t2_%0d", k), rt[k] + 3, (k - 1) / 4 + 1, 1, 0);
    exp_none("t2");

    // Line stuck low after lock: timeout then periodic zero reports
    do_reset();
    per_f(750, 250);
    per_f(750, 250);
    repeat (2100) @(negedge clk);
    exp_ev(0, "t2z_lock", rt[1] + 3, 6, 1, 0);
    for (int k = 0; k < 3; k++)
      exp_ev(0, $sformatf("t2z_%0d", k), rt[1] + 1065 + 1000 * k, 0, 0, 0);
    exp_none("t2z");

    // Back type, 125-cycle pulse ending at each falling edge
    do_reset();
    repeat (4) per_b(125, 875);
    for (int k = 1; k <= 3; k++) exp_ev(1, $sformatf("t3_%0d", k), rt[k] + 3, 1, 1, 0);
    exp_none("t3");

    // Tolerance band edges
    do_reset();
    per_f(500, 500);
    per_f(500, 500);
    per_f(500, 562);
    per_f(500, 563);
    per_f(500, 500);
    per_f(500, 437);
    per_f(500, 500);
    close_f();
    exp_ev(0, "t4_a", rt[1] + 3, 4, 1, 0);
    exp_ev(0, "t4_b", rt[2] + 3, 4, 1, 0);
    exp_ev(0, "t4_1062", rt[3] + 3, 4, 1, 0);
    exp_ev(0, "t4_tmo", rt[3] + 1065, 0, 0, 0);
    exp_ev(0, "t4_relock", rt[5] + 3, 4, 1, 0);
    exp_ev(0, "t4_937", rt[6] + 3, 4, 0, 1);
    exp_ev(0, "t4_restore", rt[7] + 3, 4, 1, 0);
    exp_none("t4");

    // Rounding and saturation
    do_reset();
    per_f(62, 938);
    per_f(63, 937);
    per_f(999, 1);
    close_f();
    exp_ev(0, "t5_62", rt[1] + 3, 0, 1, 0);
    exp_ev(0, "t5_63", rt[2] + 3, 1, 1, 0);
    exp_ev(0, "t5_999", rt[3] + 3, 7, 1, 0);
    exp_none("t5");

    // Reset in the middle of a high phase while locked
    do_reset();
    per_f(750, 250);
    per_f(750, 250);
    pwm_f = 1'b1;
    repeat (300) @(negedge clk);
    exp_ev(0, "t6_pre", rt[1] + 3, 6, 1, 0);
    chk("t6_data_before", f_data, 6);
    chk("t6_locked_before", f_locked, 1);
    rst = 1'b1;
    #1;
    chk_zero("t6_async");
    do_reset();
    per_f(750, 250);
    close_f();
    exp_ev(0, "t6_post", rt[1] + 3, 6, 1, 0);
    exp_none("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
